// File: rtl/muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
//   md_op_t    : operation select (mult, multu, div, divu)
//   md_state_t : sequencing states of the iterative unit
package alu_package;

  typedef enum logic [1:0] {
    md_mult  = 2'd0,
    md_multu = 2'd1,
    md_div   = 2'd2,
    md_divu  = 2'd3
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } md_state_t;

  function automatic logic md_is_div(md_op_t op);
    return (op == md_div) || (op == md_divu);
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return (op == md_mult) || (op == md_div);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the pipeline controller and muldiv_unit.
//   master (controller): drives start_valid, op, a, b, flush
//   slave  (unit)      : drives start_ready, busy, done, div_by_zero, hi, lo
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_package::*;

  logic             start_valid;
  logic             start_ready;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_valid, op, a, b, flush,
    input  start_ready, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start_valid, op, a, b, flush,
    output start_ready, busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_step.sv
// One iteration of the magnitude multiply/divide, purely combinational.
//   i_is_div : 1 = restoring shift-subtract, 0 = radix-2 shift-add
//   i_acc    : mult {partial product, remaining multiplier bits}
//              div  {partial remainder, remaining dividend / quotient bits}
//   i_opnd   : multiplicand (mult) or divisor (div) magnitude
//   o_acc    : accumulator after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Carry out of the add is kept as the new top bit before the right shift.
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    // Remainder shifted left with the next dividend bit; one extra bit so the
    // trial subtraction's borrow lands in bit WIDTH.
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    if (i_is_div) begin
      if (!w_diff[WIDTH]) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit writing HI/LO.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   md (slave) : start_valid/start_ready issue handshake, op/a/b operands,
//                flush abort, busy, done pulse qualified by div_by_zero,
//                hi/lo result registers
// Latency is WIDTH+3 cycles from accept to done, or 2 for divide by zero.
module muldiv_unit
  import alu_package::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave md
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_t          r_state;
  md_state_t          w_state_nxt;
  md_op_t             r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_done;
  logic               r_dbz;

  logic               w_accept;
  logic               w_is_div;
  logic               w_signed;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_accept = md.start_valid && (r_state == IDLE) && !md.flush;
  assign w_is_div = md_is_div(r_op);
  assign w_signed = md_is_signed(r_op);
  assign w_b_zero = (r_b == '0);
  assign w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_step)
  );

  always_comb begin
    w_prod   = r_neg_lo ? -r_acc : r_acc;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      w_fix_lo = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = PREP;
      PREP:    w_state_nxt = (w_is_div && w_b_zero) ? DONE : RUN;
      RUN:     if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (md.flush && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= md_mult;
      r_a      <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= md.op;
        r_a  <= md.a;
        r_b  <= md.b;
      end
      if (r_state == PREP) begin
        r_cnt    <= '0;
        r_neg_lo <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_neg_hi <= w_signed && r_a[WIDTH-1];
        if (w_is_div) begin
          r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
          r_opnd <= w_mag_b;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
          r_opnd <= w_mag_a;
        end
        if (w_is_div && w_b_zero && !md.flush) begin
          r_hi <= r_a;
          r_lo <= '1;
        end
      end
      if (r_state == RUN) begin
        r_acc <= w_acc_step;
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
      if ((r_state == FIX) && !md.flush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
      // Both flags are only ever high during DONE; a flush has already
      // redirected w_state_nxt away from DONE, suppressing them.
      r_done <= (w_state_nxt == DONE);
      r_dbz  <= (w_state_nxt == DONE) && (r_state == PREP);
    end
  end

  assign md.start_ready = (r_state == IDLE);
  assign md.busy        = (r_state != IDLE);
  assign md.done        = r_done;
  assign md.div_by_zero = r_dbz;
  assign md.hi          = r_hi;
  assign md.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  import alu_package::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) u_if ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (u_if)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Architectural result straight from integer arithmetic.
  task automatic ref_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      md_mult: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      md_multu: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dbz = 1'b1;
          hi  = a;
          lo  = '1;
        end else if (op == md_div) begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endtask

  // Issues one operation at a negedge and follows it to done, checking
  // latency, result and the busy/ready window. hold keeps start_valid high.
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] eh, el;
    logic ed;
    int lat, exp_lat;
    bit ready_seen;
    ref_md(op, a, b, eh, el, ed);
    exp_lat = ed ? 2 : 35;
    for (int i = 0; i < 100 && !u_if.start_ready; i++) @(negedge clk);
    u_if.start_valid = 1'b1;
    u_if.op = op;
    u_if.a  = a;
    u_if.b  = b;
    @(negedge clk);
    if (!hold) u_if.start_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (u_if.start_ready || !u_if.busy) ready_seen = 1'b1;
      if (u_if.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    u_if.start_valid = 1'b0;
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("hi", u_if.hi, eh);
    check_eq("lo", u_if.lo, el);
    check_eq("div_by_zero", u_if.div_by_zero, ed);
    check_eq("busy_window", ready_seen, 1'b0);
    @(negedge clk);
    check_eq("done_pulse", u_if.done, 1'b0);
    check_eq("ready_after", u_if.start_ready, 1'b1);
  endtask

  initial begin
    md_op_t rop;
    logic [31:0] ra, rb;
    bit done_seen;

    u_if.start_valid = 1'b0;
    u_if.op    = md_mult;
    u_if.a     = '0;
    u_if.b     = '0;
    u_if.flush = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hi", u_if.hi, 32'd0);
    check_eq("rst_lo", u_if.lo, 32'd0);
    check_eq("rst_done", u_if.done, 1'b0);
    check_eq("rst_ready", u_if.start_ready, 1'b1);
    check_eq("rst_busy", u_if.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(md_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(md_mult,  32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(md_div,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(md_divu,  32'd7, 32'd2, 1'b0);
    run_op(md_div,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(md_divu,  32'h1234_5678, 32'd0, 1'b0);
    run_op(md_div,   32'h8765_4321, 32'd0, 1'b0);
    run_op(md_div,   32'd7, 32'hFFFF_FFFE, 1'b0);

    // Asynchronous reset in the middle of a multiply, hi/lo non-zero before.
    u_if.start_valid = 1'b1;
    u_if.op = md_multu;
    u_if.a  = 32'd1234;
    u_if.b  = 32'd5678;
    @(negedge clk);
    u_if.start_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_hi", u_if.hi, 32'd0);
    check_eq("arst_lo", u_if.lo, 32'd0);
    check_eq("arst_busy", u_if.busy, 1'b0);
    check_eq("arst_ready", u_if.start_ready, 1'b1);
    check_eq("arst_done", u_if.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush in cycle 10 of a mult: prior hi/lo (1,3) must survive.
    run_op(md_divu, 32'd7, 32'd2, 1'b0);
    u_if.start_valid = 1'b1;
    u_if.op = md_mult;
    u_if.a  = 32'd5;
    u_if.b  = 32'd6;
    @(negedge clk);
    u_if.start_valid = 1'b0;
    done_seen = 1'b0;
    for (int n = 1; n < 10; n++) begin
      if (u_if.done) done_seen = 1'b1;
      @(negedge clk);
    end
    u_if.flush = 1'b1;
    @(negedge clk);
    u_if.flush = 1'b0;
    if (u_if.done) done_seen = 1'b1;
    check_eq("flush_ready", u_if.start_ready, 1'b1);
    check_eq("flush_busy", u_if.busy, 1'b0);
    check_eq("flush_no_done", done_seen, 1'b0);
    check_eq("flush_hi", u_if.hi, 32'd1);
    check_eq("flush_lo", u_if.lo, 32'd3);
    run_op(md_mult, 32'd5, 32'd6, 1'b0);

    // flush together with start_valid in IDLE is not an accept.
    u_if.start_valid = 1'b1;
    u_if.flush = 1'b1;
    u_if.op = md_multu;
    @(negedge clk);
    u_if.start_valid = 1'b0;
    u_if.flush = 1'b0;
    check_eq("flush_start_busy", u_if.busy, 1'b0);

    // start_valid held through the whole operation.
    run_op(md_div, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    check_eq("hold_single_op", u_if.busy, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = md_op_t'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(rop, ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit. It is the sequential counterpart to the single-cycle integer ALU in the processor datapath: the ALU covers add/sub/logic/slt/lui in one cycle, and this block covers MIPS mult/multu/div/divu into HI/LO registers. It sits beside the ALU in the execute stage. The pipeline controller issues through a valid/ready handshake and stalls on busy until done.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request operation
start_ready  output  1  unit can accept (state==IDLE)
op  input  2  md_op_t: md_mult, md_multu, md_div, md_divu
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  abort any operation in flight
busy  output  1  state != IDLE
done  output  1  one-cycle pulse; hi/lo valid with new result
div_by_zero  output  1  qualifies done; set when divide had b==0
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, busy=0, start_ready=1.
- Accept: accept = start_valid & start_ready & ~flush. Call the accept cycle cycle 0. op, a and b are captured at the end of cycle 0. start_valid while busy is ignored, with no queueing.
- States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
- PREP (cycle 1): record the result signs (signed ops only) and take operand magnitudes. If op is a divide and b==0, go directly to DONE. Otherwise clear the iteration counter and go to RUN.
- RUN (cycles 2..WIDTH+1): exactly WIDTH iterations.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - The counter wraps at WIDTH-1, and that iteration transitions to FIX.
- FIX (cycle WIDTH+2): apply sign correction. Write hi/lo at the end of this cycle.
  - Signed multiply: negate the 2*WIDTH product if operand signs differ.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- DONE (cycle WIDTH+3): done=1 and new hi/lo are visible. div_by_zero is 0 for normal completion. Unconditionally go to IDLE the next cycle. Normal latency is fixed at WIDTH+3 cycles from accept to done.
- Divide by zero: DONE in cycle 2 with div_by_zero=1, lo = all ones, hi = a unchanged. Applies to both signed and unsigned.
- Signed overflow: div of -2^(WIDTH-1) by -1 gives lo = 0x80000000, hi = 0 (falls out of the magnitude algorithm). No flag is raised.
- hi/lo hold their value except at the FIX write or the divide-by-zero write. There are no separate mfhi/mflo ports; the reader samples hi/lo directly.
- flush: in any non-IDLE state, go to IDLE at the next edge. hi/lo are untouched and done is not produced. flush together with start_valid in IDLE means no accept. flush during DONE still leaves done high for that cycle, because the write has already happened.
- Reset asserted mid-operation: immediate return to the reset values.
- done and div_by_zero are registered outputs. start_ready and busy are decoded from state.

Decomposition:
- Package alu_package gains:
  - typedef enum logic [1:0] md_op_t {md_mult=0, md_multu=1, md_div=2, md_divu=3}
  - typedef enum md_state_t {IDLE, PREP, RUN, FIX, DONE}
- The iteration step (shift-add / shift-subtract on accumulator and remainder) is a natural sub-module: muldiv_step, purely combinational. Control FSM, counter and HI/LO stay in muldiv_unit.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> hi=lo=0, done=0, start_ready=1, busy=0 immediately.
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done high exactly in cycle 35 after accept; start_ready=0 cycles 1..35.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); div_by_zero=0.
- Divides:
  - div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7 b=2 -> lo=3, hi=1.
  - div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x12345678 b=0 -> done in cycle 2, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
- Flush and back-to-back:
  - Start mult 5x6, assert flush in cycle 10 -> no done, hi/lo keep the prior values, start_ready=1 in cycle 11.
  - Re-issue in the same cycle start_ready rises -> hi=0, lo=30.
  - start_valid held high while busy -> exactly one operation executes.
